// File: rtl/button_debouncer.sv
// Push-button front end: 2-FF synchronizer, sample-tick debounce, and a
// RELEASED/PRESSED/HELD tracker producing level and pulse events.
// Optional auto-repeat while held: define BUTTON_DEBOUNCER_REPEAT_EN.
module button_debouncer #(
  parameter int unsigned DebounceSamples = 7500,
  parameter int unsigned LongSamples     = 750000,
  parameter int unsigned RepeatSamples   = 150000,
  parameter int unsigned CntSize         = 20
) (
  input  logic       clk,
  input  logic       rstx,
  input  logic       btnx,
  input  logic       sample_en,
  output logic       pressed,
  output logic       held,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic [7:0] press_count
);

  localparam logic [CntSize-1:0] DebLast  = CntSize'(DebounceSamples - 1);
  localparam logic [CntSize-1:0] LongLast = CntSize'(LongSamples - 1);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  state_t             state;
  logic [1:0]         sync;
  logic [CntSize-1:0] deb_cnt;
  logic [CntSize-1:0] hold_cnt;
  logic               btn_s;
  logic               differ;
  logic               accept;

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
  localparam logic [CntSize-1:0] RepLast = CntSize'(RepeatSamples - 1);
  logic [CntSize-1:0] rep_cnt;
`else
  logic unused_rep;
  assign unused_rep   = ^RepeatSamples;
  assign repeat_pulse = 1'b0;
`endif

  // Two-stage synchronizer on the raw pin; resets to "released" (high)
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], btnx};
    end
  end

  // Active-high synchronized level and change-acceptance decision
  always_comb begin
    btn_s  = ~sync[1];
    differ = btn_s ^ pressed;
    accept = sample_en & differ & (deb_cnt == DebLast);
  end

  // Consecutive-differing-sample counter; restarts on agreement or acceptance
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      deb_cnt <= '0;
    end else if (sample_en) begin
      if (!differ || accept) begin
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CntSize'(1);
      end
    end
  end

  // Button state tracker with registered levels, pulses and press counter
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      state         <= ST_RELEASED;
      hold_cnt      <= '0;
      pressed       <= 1'b0;
      held          <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= 8'd0;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
      rep_cnt       <= '0;
      repeat_pulse  <= 1'b0;
`endif
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
      repeat_pulse  <= 1'b0;
`endif
      case (state)
        ST_RELEASED: begin
          if (accept) begin
            state       <= ST_PRESSED;
            pressed     <= 1'b1;
            press_pulse <= 1'b1;
            press_count <= press_count + 8'd1;
            hold_cnt    <= '0;
          end
        end
        ST_PRESSED: begin
          if (sample_en) begin
            hold_cnt <= hold_cnt + CntSize'(1);
            // A release on the same sample as the long-press threshold wins
            if (accept) begin
              state         <= ST_RELEASED;
              pressed       <= 1'b0;
              release_pulse <= 1'b1;
            end else if (hold_cnt == LongLast) begin
              state      <= ST_HELD;
              held       <= 1'b1;
              long_pulse <= 1'b1;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
              rep_cnt    <= '0;
`endif
            end
          end
        end
        ST_HELD: begin
          if (accept) begin
            state         <= ST_RELEASED;
            pressed       <= 1'b0;
            held          <= 1'b0;
            release_pulse <= 1'b1;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
            rep_cnt       <= '0;
          end else if (sample_en) begin
            if (rep_cnt == RepLast) begin
              rep_cnt      <= '0;
              repeat_pulse <= 1'b1;
              press_count  <= press_count + 8'd1;
            end else begin
              rep_cnt <= rep_cnt + CntSize'(1);
            end
`endif
          end
        end
        default: begin
          state   <= ST_RELEASED;
          pressed <= 1'b0;
          held    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized bench for button_debouncer against an event-level reference model.
module tb_button_debouncer;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 16;
  localparam int unsigned REP  = 4;
  localparam int unsigned CW   = 5;

  logic       clk = 1'b0;
  logic       rstx = 1'b1;
  logic       btnx = 1'b1;
  logic       sample_en = 1'b1;
  logic       pressed, held, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic [7:0] press_count;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  button_debouncer #(
    .DebounceSamples(DEB),
    .LongSamples    (LONG),
    .RepeatSamples  (REP),
    .CntSize        (CW)
  ) dut (
    .clk          (clk),
    .rstx         (rstx),
    .btnx         (btnx),
    .sample_en    (sample_en),
    .pressed      (pressed),
    .held         (held),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .press_count  (press_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pin history queue, run length of disagreeing samples,
  // samples since press, samples since entering long-press.
  bit         pin_q[$];
  bit         m_pressed, m_held, m_pp, m_rp, m_lp, m_rep;
  int         run_len, age, rep_age;
  logic [7:0] m_count;

  task automatic m_reset();
    pin_q = '{1'b1, 1'b1};
    m_pressed = 0; m_held = 0;
    m_pp = 0; m_rp = 0; m_lp = 0; m_rep = 0;
    run_len = 0; age = 0; rep_age = 0;
    m_count = 8'd0;
  endtask

  task automatic m_step();
    bit level;
    bit acc;
    level = !pin_q[$];
    pin_q.push_front(bit'(btnx));
    void'(pin_q.pop_back());
    m_pp = 0; m_rp = 0; m_lp = 0; m_rep = 0;
    if (sample_en) begin
      run_len = (level != m_pressed) ? run_len + 1 : 0;
      acc = (run_len == int'(DEB));
      if (acc) run_len = 0;
      if (!m_pressed) begin
        if (acc) begin
          m_pressed = 1; m_pp = 1; m_count = m_count + 8'd1; age = 0;
        end
      end else if (!m_held) begin
        age++;
        if (acc) begin
          m_pressed = 0; m_rp = 1;
        end else if (age == int'(LONG)) begin
          m_held = 1; m_lp = 1; rep_age = 0;
        end
      end else begin
        if (acc) begin
          m_pressed = 0; m_held = 0; m_rp = 1; rep_age = 0;
        end
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
        else begin
          rep_age++;
          if (rep_age == int'(REP)) begin
            m_rep = 1; rep_age = 0; m_count = m_count + 8'd1;
          end
        end
`endif
      end
    end
  endtask

  // Model advances on the same edges as the design
  always @(posedge clk or negedge rstx) begin
    if (!rstx) m_reset();
    else m_step();
  end

  // Compare every output against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("flags", {2'b00, pressed, held, press_pulse, release_pulse, long_pulse, repeat_pulse},
            {2'b00, m_pressed, m_held, m_pp, m_rp, m_lp, m_rep});
      check("count", press_count, m_count);
    end
  end

  task automatic apply(input logic b, input logic se, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      btnx = b;
      sample_en = se;
    end
  endtask

  task automatic apply_rnd_se(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      btnx = b;
      sample_en = logic'($urandom % 2);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 rstx = 1'b0;
    #1;
    check("rst_flags", {2'b00, pressed, held, press_pulse, release_pulse, long_pulse, repeat_pulse}, 8'd0);
    check("rst_count", press_count, 8'd0);
    @(negedge clk);
    #2 rstx = 1'b1;
  endtask

  initial begin
    m_reset();
    #3 rstx = 1'b0;
    #1 chk_en = 1'b1;
    check("por_flags", {2'b00, pressed, held, press_pulse, release_pulse, long_pulse, repeat_pulse}, 8'd0);
    check("por_count", press_count, 8'd0);
    apply(1'b1, 1'b1, 2);
    rstx = 1'b1;
    apply(1'b1, 1'b1, 4);

    // Bouncy press, long hold, bouncy release
    apply(1'b0, 1'b1, 3);
    apply(1'b1, 1'b1, 1);
    apply(1'b0, 1'b1, 6);
    apply(1'b0, 1'b1, 24);
    check("held_after_hold", {7'd0, held}, 8'd1);
    check("count_after_hold", press_count, 8'd1);
    apply(1'b1, 1'b1, 2);
    apply(1'b0, 1'b1, 1);
    apply(1'b1, 1'b1, 8);
    check("released", {6'd0, pressed, held}, 8'd0);

    // Long hold to exercise the repeat path
    apply(1'b0, 1'b1, 36);
    apply(1'b1, 1'b1, 8);

    // Random bouncing, first with continuous sampling then with a sparse tick
    for (int s = 0; s < 300; s++) begin
      logic b;
      int   len;
      b   = logic'($urandom % 2);
      len = ($urandom % 3 == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 40));
      if (s < 150) apply(b, 1'b1, len);
      else apply_rnd_se(b, len);
    end

    // Reset mid-run with the button held down
    apply(1'b0, 1'b1, 3);
    reset_pulse();
    apply(1'b0, 1'b1, 10);
    check("press_after_rst", press_count, 8'd1);
    apply(1'b1, 1'b1, 10);

    // 256 clean presses wrap the counter back to zero
    apply(1'b1, 1'b1, 1);
    reset_pulse();
    apply(1'b1, 1'b1, 3);
    for (int p = 0; p < 256; p++) begin
      apply(1'b0, 1'b1, 8);
      apply(1'b1, 1'b1, 8);
    end
    check("wrap", press_count, 8'd0);

    // Bounce with no sample tick: nothing may move
    for (int i = 0; i < 60; i++) apply(logic'($urandom % 2), 1'b0, 1);
    check("frozen_count", press_count, 8'd0);
    check("frozen_pressed", {7'd0, pressed}, 8'd0);
    apply(1'b1, 1'b1, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
